// File: rtl/rng_pkg.sv
// Shared definitions for the 33-bit shift-register pseudorandom generator
// and its sequence checker.
package rng_pkg;

    localparam int unsigned RNG_STATE_W = 33;
    localparam int unsigned RNG_OUT_W   = 32;
    localparam int unsigned RNG_TAP_A   = 12;
    localparam int unsigned RNG_TAP_B   = 11;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } rc_state_e;

    // One generator step: shift left, feed back the XOR of the two taps.
    function automatic logic [RNG_STATE_W-1:0] rng_step(input logic [RNG_STATE_W-1:0] s);
        return {s[RNG_STATE_W-2:0], s[RNG_TAP_A] ^ s[RNG_TAP_B]};
    endfunction

endpackage

// File: rtl/rng_predict.sv
// Combinational next-state prediction and compare against the observed word.
module rng_predict
    import rng_pkg::*;
(
    input  logic [RNG_STATE_W-1:0] state,
    input  logic [RNG_OUT_W-1:0]   word,
    output logic [RNG_STATE_W-1:0] pred_c,
    output logic                   match_c
);

    assign pred_c  = rng_step(state);
    assign match_c = (word == pred_c[RNG_OUT_W-1:0]);

endmodule

// File: rtl/random_check.sv
// Sequence checker: acquires the generator state from two consecutive words,
// then predicts and compares every following word.
module random_check
    import rng_pkg::*;
#(
    parameter int unsigned MISS_LIMIT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [RNG_OUT_W-1:0] in_data,
    output logic                 locked,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     err_count,
    output logic                 lost
);

    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    rc_state_e              state;
    logic [RNG_STATE_W-1:0] s_reg;
    logic [RNG_OUT_W-1:0]   prev;
    logic [MISS_W-1:0]      miss_cnt;

    logic [RNG_STATE_W-1:0] pred_c;
    logic                   match_c;
    logic [RNG_STATE_W-1:0] acq_state_c;
    logic                   consistent_c;
    logic                   miss_last_c;

    // Two words are consistent when the second is the first shifted left by one.
    assign acq_state_c  = {prev[RNG_OUT_W-1], in_data};
    assign consistent_c = (in_data[RNG_OUT_W-1:1] == prev[RNG_OUT_W-2:0]);
    assign miss_last_c  = ((miss_cnt + MISS_W'(1)) == MISS_W'(MISS_LIMIT));

    rng_predict u_predict (
        .state   (s_reg),
        .word    (in_data),
        .pred_c  (pred_c),
        .match_c (match_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HUNT;
            s_reg     <= '0;
            prev      <= '0;
            miss_cnt  <= '0;
            err_count <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            lost      <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            lost     <= 1'b0;
            if (in_valid) begin
                case (state)
                    ST_HUNT: begin
                        // All-zero is the generator lockup word; never acquire on it.
                        if (in_data != '0) begin
                            prev  <= in_data;
                            state <= ST_ACQ;
                        end
                    end
                    ST_ACQ: begin
                        if (consistent_c && (acq_state_c != '0)) begin
                            s_reg    <= acq_state_c;
                            miss_cnt <= '0;
                            locked   <= 1'b1;
                            state    <= ST_LOCKED;
                        end else begin
                            prev <= in_data;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running model: never resynced from the data.
                        s_reg <= pred_c;
                        if (!match_c) begin
                            mismatch <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (miss_last_c) begin
                                lost     <= 1'b1;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                                state    <= ST_HUNT;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        locked <= 1'b0;
                        state  <= ST_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_random_check.sv
// Self-checking bench for random_check: behavioural reference with a result
// queue, plus directed expectations at the interesting points.
module tb_random_check;

    localparam int MISS_LIMIT = 4;
    localparam int M_HUNT = 0, M_ACQ = 1, M_LOCK = 2;

    typedef struct {
        logic        locked;
        logic        mismatch;
        logic        lost;
        logic [15:0] err;
        logic [1:0]  err2;
        logic        mismatch2;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        locked, mismatch, lost;
    logic [15:0] err_count;
    logic        locked2, mismatch2, lost2;
    logic [1:0]  err_count2;

    int n_vec;
    int n_err;
    int n_mm2;

    exp_t sb_q[$];

    // Reference model state
    int          ms;
    logic [31:0] mprev;
    logic [32:0] mstate;
    int          mmiss;
    int          merr;
    int          merr2;

    // Stimulus generator state (word emitted is g[31:0], then g steps)
    logic [32:0] g;

    random_check #(.MISS_LIMIT(MISS_LIMIT), .CNT_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .mismatch  (mismatch),
        .err_count (err_count),
        .lost      (lost)
    );

    random_check #(.MISS_LIMIT(MISS_LIMIT), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked2),
        .mismatch  (mismatch2),
        .err_count (err_count2),
        .lost      (lost2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic v, input logic [31:0] d, input logic r, output exp_t e);
        logic [32:0] p;
        e.mismatch = 1'b0;
        e.lost     = 1'b0;
        if (r) begin
            ms = M_HUNT; mprev = '0; mstate = '0; mmiss = 0; merr = 0; merr2 = 0;
        end else if (v) begin
            if (ms == M_HUNT) begin
                if (d != 32'h0) begin
                    mprev = d;
                    ms = M_ACQ;
                end
            end else if (ms == M_ACQ) begin
                if ((d >> 1) == {1'b0, mprev[30:0]} && {mprev[31], d} != 33'h0) begin
                    mstate = {mprev[31], d};
                    mmiss = 0;
                    ms = M_LOCK;
                end else begin
                    mprev = d;
                end
            end else begin
                p = {mstate[31:0], mstate[12] ^ mstate[11]};
                mstate = p;
                if (d != p[31:0]) begin
                    e.mismatch = 1'b1;
                    if (merr < 65535) merr++;
                    if (merr2 < 3) merr2++;
                    mmiss++;
                    if (mmiss == MISS_LIMIT) begin
                        e.lost = 1'b1;
                        ms = M_HUNT;
                        mmiss = 0;
                    end
                end else begin
                    mmiss = 0;
                end
            end
        end
        e.locked    = (ms == M_LOCK);
        e.err       = 16'(merr);
        e.err2      = 2'(merr2);
        e.mismatch2 = e.mismatch;
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        exp_t e;
        exp_t got_e;
        in_valid = v;
        in_data  = d;
        reset    = r;
        model(v, d, r, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check("locked",    64'(locked),     64'(got_e.locked));
        check("mismatch",  64'(mismatch),   64'(got_e.mismatch));
        check("lost",      64'(lost),       64'(got_e.lost));
        check("err_count", 64'(err_count),  64'(got_e.err));
        check("err_sat",   64'(err_count2), 64'(got_e.err2));
        check("mism_sat",  64'(mismatch2),  64'(got_e.mismatch2));
        if (mismatch2) n_mm2++;
    endtask

    task automatic good();
        cyc(1'b1, g[31:0], 1'b0);
        g = {g[31:0], g[12] ^ g[11]};
    endtask

    task automatic bad();
        cyc(1'b1, g[31:0] ^ 32'h1, 1'b0);
        g = {g[31:0], g[12] ^ g[11]};
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_mm2 = 0;
        ms = M_HUNT; mprev = '0; mstate = '0; mmiss = 0; merr = 0; merr2 = 0;
        in_valid = 1'b0; in_data = '0; reset = 1'b1;

        // Reset state
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);

        // Clean lock: 1, 2, 4, ...
        g = 33'h1;
        good();
        check("lock_c2", 64'(locked), 64'd0);
        good();
        check("lock_c3", 64'(locked), 64'd1);
        for (int i = 2; i < 1000; i++) good();
        check("clean_err", 64'(err_count), 64'd0);
        check("clean_locked", 64'(locked), 64'd1);

        // Single error
        bad();
        check("single_mm", 64'(mismatch), 64'd1);
        check("single_err", 64'(err_count), 64'd1);
        check("single_locked", 64'(locked), 64'd1);
        good();
        check("single_after", 64'(mismatch), 64'd0);

        // MISS_LIMIT-1 misses then a match stays locked
        for (int i = 0; i < MISS_LIMIT - 1; i++) bad();
        good();
        check("near_loss_locked", 64'(locked), 64'd1);
        check("near_loss_lost", 64'(lost), 64'd0);

        // Loss of lock
        for (int i = 0; i < MISS_LIMIT; i++) bad();
        check("loss_lost", 64'(lost), 64'd1);
        check("loss_locked", 64'(locked), 64'd0);
        check("loss_err", 64'(err_count), 64'(1 + 2 * MISS_LIMIT - 1));
        good();
        good();
        check("relock", 64'(locked), 64'd1);
        good();

        // Acquisition rejection
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0);
        cyc(1'b1, 32'h1, 1'b0);
        check("hunt_zero", 64'(locked), 64'd0);
        cyc(1'b1, 32'h1234_5678, 1'b0);
        cyc(1'b1, 32'h1, 1'b0);
        check("acq_reject", 64'(locked), 64'd0);
        cyc(1'b1, 32'h2, 1'b0);
        check("acq_lock", 64'(locked), 64'd1);
        g = 33'h4;
        for (int i = 0; i < 20; i++) good();

        // Gaps while locked
        for (int i = 0; i < 5; i++) idle();
        for (int i = 0; i < 10; i++) good();
        check("gap_err", 64'(err_count), 64'd0);
        check("gap_locked", 64'(locked), 64'd1);

        // Reset coincident with a corrupted word
        cyc(1'b1, g[31:0] ^ 32'h1, 1'b1);
        check("rst_mm", 64'(mismatch), 64'd0);
        check("rst_lk", 64'(locked), 64'd0);
        check("rst_ls", 64'(lost), 64'd0);
        check("rst_ec", 64'(err_count), 64'd0);

        // Saturation: five isolated errors
        g = 33'h1;
        n_mm2 = 0;
        for (int i = 0; i < 40; i++) good();
        for (int k = 0; k < 5; k++) begin
            bad();
            for (int i = 0; i < 3; i++) good();
        end
        check("sat_err2", 64'(err_count2), 64'd3);
        check("sat_pulses", 64'(n_mm2), 64'd5);
        check("sat_err16", 64'(err_count), 64'd5);
        for (int i = 0; i < 5; i++) good();
        check("sat_hold", 64'(err_count2), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/random_check.md
# random_check

Sequence checker for the 33-bit shift-register pseudorandom generator used by the solver's randomized variable selection. It consumes the generator's 32-bit output word stream, derives the full 33-bit internal state from two consecutive words, and predicts every following word. Each mismatch is flagged, and the checker recovers by re-acquiring. It sits beside the generator in integration benches and in the optional on-chip self-test path.

## Interface
- `MISS_LIMIT`, default 4: consecutive mismatches while locked that force re-acquisition (≥1).
- `CNT_W`, default 16: width of the saturating error counter.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: `in_data` holds the next generator word this cycle.
- `in_data` input, 32 bits: generator output word (state bits 31:0).
- `locked` output, 1 bit: the checker is in the LOCKED state.
- `mismatch` output, 1 bit: one-cycle pulse; the previous valid word differed from the prediction.
- `err_count` output, `CNT_W` bits: total mismatches since reset; saturates at all-ones.
- `lost` output, 1 bit: one-cycle pulse when the checker drops from LOCKED to HUNT.

## Operation
- Generator model, state S[32:0] per step:
  - S' = {S[31:0], S[12]^S[11]}
  - The visible word is S'[31:0]. All arithmetic is bitwise; there is no carry.
- Steps advance only on `in_valid` cycles. Idle cycles hold all state.
- State machine:
  - **HUNT**:
    - On a valid word, capture it into `prev` and go to ACQ.
    - An all-zero word stays in HUNT, because all-zero is the generator lockup state.
  - **ACQ**:
    - On a valid word w, check consistency: w[31:1] == prev[30:0].
    - If consistent, build S = {prev[31], w[31:0]}.
    - If S ≠ 0, load S, clear the miss counter and go to LOCKED.
    - If inconsistent, or S = 0, capture w into `prev` and stay in ACQ. No mismatch is flagged during acquisition.
  - **LOCKED**:
    - On each valid word, compute P = {S[31:0], S[12]^S[11]}.
    - Always load S ← P; the model free-runs and is not resynced from the data.
    - If w ≠ P[31:0]: pulse `mismatch`, increment `err_count` (saturating) and increment the miss counter.
    - If the miss counter reaches `MISS_LIMIT`: pulse `lost` and go to HUNT.
    - On a match, clear the miss counter.
- Reset values:
  - State HUNT.
  - `locked`, `mismatch`, `lost` = 0.
  - `err_count` = 0, S = 0, `prev` = 0, miss counter = 0.
- Reset mid-operation overrides everything in the same edge, including a pending mismatch.
- Boundary rules:
  - `err_count` at all-ones stays there, but `mismatch` still pulses.
  - Miss counter width is clog2(`MISS_LIMIT`+1).

## Timing
- All outputs are registered.
- `mismatch` and `lost` are high for exactly the cycle after the edge that sampled the offending word.
- `locked` rises the cycle after the second consistent word and falls in the same cycle `lost` pulses.
- Minimum lock latency: 2 valid words, so `locked` is high in cycle 3 for back-to-back input.
- Throughput: one word per clock, no backpressure and no ready signal.
- When a match follows `MISS_LIMIT`-1 misses, the miss counter clears and the checker stays LOCKED.

## Structure
- Shared package `rng_pkg`:
  - `RNG_STATE_W` = 33, `RNG_OUT_W` = 32.
  - Tap indices 12 and 11.
  - The state-enum typedef.
  - The next-state function `rng_step`, also used by the generator.
- One sub-module, `rng_predict`: combinational P from S via `rng_step`, plus the 32-bit compare. Instantiated once.
- The FSM, counters and `prev` register live in `random_check`, roughly 150–250 lines.

## Test plan
- **Clean lock.** Reset, then drive 0x00000001, 0x00000002, 0x00000004, … back-to-back.
  - `locked` = 1 in cycle 3.
  - After 0x00000800 the checker accepts 0x00001001.
  - `err_count` = 0 after 1000 words.
- **Single error.** Once locked, replace one word with its bit 0 flipped.
  - One `mismatch` pulse the next cycle, `err_count` = 1.
  - `locked` stays 1, and the following correct word produces no pulse.
- **Loss of lock.** Send `MISS_LIMIT` = 4 consecutive corrupted words.
  - Four `mismatch` pulses; `lost` pulses with the 4th; `locked` = 0.
  - Resuming a valid stream relocks within 2 words.
- **Acquisition rejection.**
  - In HUNT, 0x00000000 is ignored.
  - In ACQ, 0x12345678 followed by 0x00000001 fails consistency, so the checker stays in ACQ with `prev` = 0x00000001.
  - Then 0x00000002 locks.
- **Gaps and reset.**
  - Deassert `in_valid` for 5 cycles while locked: no pulses, and the stream resumes matching.
  - Assert `reset` in the same cycle as a corrupted word: no `mismatch`, and all outputs are 0 the next cycle.
- **Saturation.** Force `CNT_W` = 2 and inject 5 isolated errors.
  - `err_count` = 3 and stays there.
  - `mismatch` pulses 5 times.
